pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Parametrised inter-stage pipeline register for the 5-stage MIPS core; one instance per D/E/M/W boundary.
//   Holds NUM_FIELDS packed WIDTH-bit fields (instr, PC+8, operands, imm, ...) plus a valid bit.
//   Adds stall-hold, flush-to-bubble with per-field keep mask (PC survives for EPC) and saturating stall/bubble perf counters.
// PARAMETERS
//   WIDTH       32         bits per field
//   NUM_FIELDS  5          number of packed fields; field i = data[i*WIDTH +: WIDTH]
//   KEEP_MASK   5'b00010   bit i=1: on flush field i loads data_in (e.g. PC); bit i=0: field cleared to 0
//   CNT_W       32         width of each perf counter
// PORTS
//   clk         in   1                   clock, rising edge
//   reset       in   1                   synchronous, active-high
//   en          in   1                   1 = load stage; 0 = hold (stall)
//   flush       in   1                   insert bubble this edge; overrides en
//   valid_in    in   1                   upstream slot holds a real instruction
//   data_in     in   NUM_FIELDS*WIDTH    packed upstream fields
//   cnt_clr     in   1                   synchronous clear of both counters
//   valid_out   out  1                   stage holds a real instruction
//   data_out    out  NUM_FIELDS*WIDTH    registered fields
//   stall_cnt   out  CNT_W               cycles spent holding a valid instruction
//   bubble_cnt  out  CNT_W               bubbles inserted by flush
// BEHAVIOUR
//   - All updates on posedge clk. Priority per edge: reset > flush > en > hold.
//   - reset: valid_out=0, data_out=0, stall_cnt=0, bubble_cnt=0.
//   - flush (reset=0), independent of en: valid_out<=0; field i <= KEEP_MASK[i] ? data_in field i : 0.
//   - en=1, flush=0: valid_out<=valid_in; data_out<=data_in. Latency 1 cycle.
//   - en=0, flush=0: valid_out, data_out unchanged (hold any number of cycles).
//   - All-zero instr field is the bubble (sll $0,$0,0 = nop); downstream decodes it as a nop.
//   - stall_cnt: +1 when en=0 && flush=0 && valid_out=1 (register value before the edge).
//   - bubble_cnt: +1 on each edge with flush=1 (reset=0), regardless of en or valid_in.
//   - Counters saturate at {CNT_W{1'b1}}, never wrap. cnt_clr zeroes both; cnt_clr beats increment on the same edge.
//   - reset overrides cnt_clr and flush. cnt_clr never touches data_out or valid_out.
//   - Reset mid-stall: state clears and the held instruction is lost. After release, en=1 loads normally.
//   - No combinational path from any input to any output.
// STRUCTURE
//   - Shared const.v: field index defines (`FLD_INSTR 0, `FLD_PC8 1, `FLD_RS 2, `FLD_RT 3, `FLD_IMM 4), `BUBBLE 32'h0, default KEEP_MASK.
//   - Data/valid path: generate loop over NUM_FIELDS with the per-field keep mux.
//   - Sub-module sat_counter (param CNT_W; ports clk, reset, clr, inc, cnt): two instances.
// TESTING
//   1 reset: reset=1 for 2 cycles with data_in=all 5 fields 32'hFFFF_FFFF -> data_out=0, valid_out=0, both counters 0.
//   2 load: en=1, valid_in=1, instr=32'h0109_5020, PC8=32'h0000_3008 -> next cycle valid_out=1, outputs equal inputs.
//   3 stall: after load, en=0 for 3 cycles while data_in changes -> data_out held, stall_cnt=3, bubble_cnt=0.
//   4 flush+stall: en=0, flush=1, PC8_in=32'h0000_300C -> valid_out=0, instr=0, PC8=32'h0000_300C, other fields 0, bubble_cnt=1.
//   5 saturation: CNT_W=4, stall valid stage 20 cycles -> stall_cnt stops at 4'hF. Then cnt_clr=1 with en=0 -> stall_cnt=0 next edge.
//   6 priority: reset=1, flush=1, cnt_clr=1 on the same edge -> full reset values, bubble_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the MIPS inter-stage pipeline registers: default
// geometry of a stage and the default set of fields kept across a flush.
package pipe_stage_reg_pkg;

  // Field layout of a stage slot: instr, PC+8, rs operand, rt operand, imm.
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_NUM_FIELDS = 5;
  localparam int DEF_CNT_W      = 32;

  // Only the PC+8 field survives a flush so the exception logic can form EPC.
  localparam logic [4:0] DEF_KEEP_MASK = 5'b00010;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with a synchronous clear. A clear on the same
// edge as an increment wins; at all-ones the counter sticks instead of
// wrapping so a long stall never reads back as a short one.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: clear beats increment, increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register; reset overrides clear and increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (one per D/E/M/W boundary). Holds
// NUM_FIELDS packed fields plus a valid bit. Control per edge, highest
// first: reset, flush (bubble), en (load), otherwise hold. A bubble clears
// every field except those in KEEP_MASK, which still load from data_in; an
// all-zero instr field decodes downstream as a nop. Two saturating counters
// track cycles spent holding a valid instruction and bubbles inserted.
// All outputs come straight from flops.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                    WIDTH      = DEF_WIDTH,
  parameter int                    NUM_FIELDS = DEF_NUM_FIELDS,
  parameter logic [NUM_FIELDS-1:0] KEEP_MASK  = DEF_KEEP_MASK,
  parameter int                    CNT_W      = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        flush,
  input  logic                        valid_in,
  input  logic [NUM_FIELDS*WIDTH-1:0] data_in,
  input  logic                        cnt_clr,
  output logic                        valid_out,
  output logic [NUM_FIELDS*WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]            stall_cnt,
  output logic [CNT_W-1:0]            bubble_cnt
);

  logic                        valid_d;
  logic                        valid_q;
  logic [NUM_FIELDS*WIDTH-1:0] data_d;
  logic [NUM_FIELDS*WIDTH-1:0] data_q;
  logic [NUM_FIELDS*WIDTH-1:0] flush_data;
  logic                        stall_inc;

  // Per-field bubble value: kept fields pass data_in, others go to zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      assign flush_data[gi*WIDTH +: WIDTH] =
        KEEP_MASK[gi] ? data_in[gi*WIDTH +: WIDTH] : {WIDTH{1'b0}};
    end
  endgenerate

  // Next slot contents: flush inserts a bubble, en loads, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = flush_data;
    end else if (en) begin
      valid_d = valid_in;
      data_d  = data_in;
    end
  end

  // Slot registers; reset discards whatever instruction was held.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // A stall cycle is a hold edge while the slot holds a real instruction.
  assign stall_inc = ~en & ~flush & valid_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (flush),
    .cnt   (bubble_cnt)
  );

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a default instance (32-bit counters) and a
// 4-bit-counter instance share the same stimulus. A rule-level model runs
// beside them and every cycle is compared; directed checks pin literals.
module tb_pipe_stage_reg;

  localparam int W  = 32;
  localparam int NF = 5;
  localparam int DW = NF * W;
  localparam logic [NF-1:0] KEEP = 5'b00010;
  localparam longint BIG_MAX   = 64'h0000_0000_FFFF_FFFF;
  localparam longint SMALL_MAX = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          cnt_clr = 1'b0;

  logic          valid_out, valid_out_s;
  logic [DW-1:0] data_out, data_out_s;
  logic [31:0]   stall_cnt, bubble_cnt;
  logic [3:0]    stall_cnt_s, bubble_cnt_s;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
    .data_in(data_in), .cnt_clr(cnt_clr), .valid_out(valid_out),
    .data_out(data_out), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
    .data_in(data_in), .cnt_clr(cnt_clr), .valid_out(valid_out_s),
    .data_out(data_out_s), .stall_cnt(stall_cnt_s), .bubble_cnt(bubble_cnt_s)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack(input logic [W-1:0] instr, pc8, rs, rt, imm);
    return {imm, rt, rs, pc8, instr};
  endfunction

  // ---------------- model + scoreboard ----------------
  logic [DW:0] exp_q[$];
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  longint m_stall_b = 0, m_bubble_b = 0, m_stall_s = 0, m_bubble_s = 0;

  function automatic longint sat_inc(input longint v, input longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  always @(posedge clk) begin
    bit was_stall;
    if (reset) begin
      m_valid = 1'b0; m_data = '0;
      m_stall_b = 0; m_bubble_b = 0; m_stall_s = 0; m_bubble_s = 0;
    end else begin
      was_stall = !en && !flush && m_valid;
      if (cnt_clr) begin
        m_stall_b = 0; m_bubble_b = 0; m_stall_s = 0; m_bubble_s = 0;
      end else begin
        if (was_stall) begin
          m_stall_b = sat_inc(m_stall_b, BIG_MAX);
          m_stall_s = sat_inc(m_stall_s, SMALL_MAX);
        end
        if (flush) begin
          m_bubble_b = sat_inc(m_bubble_b, BIG_MAX);
          m_bubble_s = sat_inc(m_bubble_s, SMALL_MAX);
        end
      end
      if (flush) begin
        m_valid = 1'b0;
        for (int i = 0; i < NF; i++)
          m_data[i*W +: W] = KEEP[i] ? data_in[i*W +: W] : '0;
      end else if (en) begin
        m_valid = valid_in;
        m_data  = data_in;
      end
    end
    exp_q.push_back({m_valid, m_data});
  end

  // Every-cycle compare, on the falling edge.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cyc_slot", {valid_out, data_out}, e);
      chk("cyc_slot_s", {valid_out_s, data_out_s}, e);
      chk("cyc_stall", {{(DW-31){1'b0}}, stall_cnt}, {{(DW-31){1'b0}}, m_stall_b[31:0]});
      chk("cyc_bubble", {{(DW-31){1'b0}}, bubble_cnt}, {{(DW-31){1'b0}}, m_bubble_b[31:0]});
      chk("cyc_stall_s", {{(DW-3){1'b0}}, stall_cnt_s}, {{(DW-3){1'b0}}, m_stall_s[3:0]});
      chk("cyc_bubble_s", {{(DW-3){1'b0}}, bubble_cnt_s}, {{(DW-3){1'b0}}, m_bubble_s[3:0]});
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_cnt(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, {{(DW-31){1'b0}}, act}, {{(DW-31){1'b0}}, exp});
  endtask

  logic [DW-1:0] ld_vec;

  initial begin
    // 1: reset with all-ones data
    reset = 1'b1; en = 1'b1; valid_in = 1'b1; data_in = '1;
    cyc(2);
    chk("rst_valid", {{DW{1'b0}}, valid_out}, '0);
    chk("rst_data", {1'b0, data_out}, '0);
    chk_cnt("rst_stall", stall_cnt, 32'd0);
    chk_cnt("rst_bubble", bubble_cnt, 32'd0);

    // 2: load
    reset = 1'b0;
    ld_vec = pack(32'h0109_5020, 32'h0000_3008, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033);
    data_in = ld_vec;
    cyc();
    chk("load", {valid_out, data_out}, {1'b1, ld_vec});

    // 3: stall three cycles while upstream changes
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = pack($urandom, $urandom, $urandom, $urandom, $urandom);
      cyc();
    end
    chk("stall_hold", {valid_out, data_out}, {1'b1, ld_vec});
    chk_cnt("stall_cnt3", stall_cnt, 32'd3);
    chk_cnt("stall_bub0", bubble_cnt, 32'd0);

    // 4: flush during stall keeps only PC+8
    flush = 1'b1;
    data_in = pack(32'hAAAA_5555, 32'h0000_300C, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_FFFF);
    cyc();
    chk("flush_slot", {valid_out, data_out}, {1'b0, pack(32'h0, 32'h0000_300C, 32'h0, 32'h0, 32'h0)});
    chk_cnt("flush_bub1", bubble_cnt, 32'd1);
    chk_cnt("flush_stall", stall_cnt, 32'd3);

    // hold on an invalid slot does not count as a stall
    flush = 1'b0;
    cyc(2);
    chk_cnt("bubble_hold_nostall", stall_cnt, 32'd3);

    // flush with en=1 and valid_in=0 still counts a bubble
    en = 1'b1; flush = 1'b1; valid_in = 1'b0;
    cyc();
    chk_cnt("flush_en_bub2", bubble_cnt, 32'd2);

    // 5: saturation on the 4-bit instance, then clear during a stall
    flush = 1'b0; valid_in = 1'b1; data_in = ld_vec;
    cyc();
    en = 1'b0;
    cyc(20);
    chk_cnt("sat_small", {28'd0, stall_cnt_s}, 32'h0000_000F);
    chk_cnt("sat_big", stall_cnt, 32'd23);
    cnt_clr = 1'b1;
    cyc();
    chk_cnt("clr_small", {28'd0, stall_cnt_s}, 32'd0);
    chk_cnt("clr_big", stall_cnt, 32'd0);
    chk_cnt("clr_bub", bubble_cnt, 32'd0);
    chk("clr_keeps_slot", {valid_out, data_out}, {1'b1, ld_vec});
    cnt_clr = 1'b0;
    cyc(2);

    // 6: reset beats flush and cnt_clr
    reset = 1'b1; flush = 1'b1; cnt_clr = 1'b1; en = 1'b1;
    cyc();
    chk("prio_slot", {valid_out, data_out}, '0);
    chk_cnt("prio_bub", bubble_cnt, 32'd0);
    chk_cnt("prio_stall", stall_cnt, 32'd0);

    // reset mid-stall, then a normal load after release
    reset = 1'b0; flush = 1'b0; cnt_clr = 1'b0; data_in = ld_vec;
    cyc();
    en = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc();
    chk("midstall_rst", {valid_out, data_out}, '0);
    reset = 1'b0; en = 1'b1;
    data_in = pack(32'h8C22_0004, 32'h0000_4010, 32'h7, 32'h8, 32'h4);
    cyc();
    chk("post_rst_load", {valid_out, data_out},
        {1'b1, pack(32'h8C22_0004, 32'h0000_4010, 32'h7, 32'h8, 32'h4)});

    // mixed directed traffic, checked by the per-cycle model
    for (int i = 0; i < 40; i++) begin
      en = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      valid_in = $urandom_range(0, 1);
      cnt_clr = ($urandom_range(0, 15) == 0);
      data_in = pack($urandom, $urandom, $urandom, $urandom, $urandom);
      cyc();
    end
    en = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
